// File: rtl/ov5640_pix_capture.sv
`timescale 1ns/1ps
// OV5640 DVP capture: skips start-up frames, packs byte pairs into RGB565,
// expands to RGB888 and writes a clipped H_PIXEL x V_PIXEL window per frame.
//
//   state      | meaning
//   ST_IDLE    | waiting for sys_init_done, nothing written
//   ST_SKIP    | discarding PIC_WAIT frames, counting vsync rising edges
//   ST_CAPTURE | writing pixels, checking line/frame geometry
module ov5640_pix_capture #(
    parameter int PIC_WAIT = 10,
    parameter int H_PIXEL  = 640,
    parameter int V_PIXEL  = 480
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sys_init_done,
    input  logic        ov5640_vsync,
    input  logic        ov5640_href,
    input  logic [7:0]  ov5640_data,
    output logic        ov5640_wr_en,
    output logic [23:0] ov5640_data_out,
    output logic        frame_start,
    output logic        line_err,
    output logic        frame_err
);

    localparam int              SKIP_W    = $clog2(PIC_WAIT + 1);
    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PIC_WAIT);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(1);
    localparam logic [11:0]     H_LIM     = 12'(H_PIXEL);
    localparam logic [11:0]     V_LIM     = 12'(V_PIXEL);
    localparam logic [11:0]     CNT_MAX   = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE
    } state_t;

    state_t              state_q;
    logic [SKIP_W-1:0]   skip_cnt_q;

    logic                v_r_q;
    logic                v_rd_q;
    logic                h_r_q;
    logic                h_rd_q;
    logic [7:0]          d_r_q;

    logic                toggle_q;
    logic                toggle_d;
    logic [7:0]          hi_q;
    logic [7:0]          hi_d;
    logic [11:0]         x_cnt_q;
    logic [11:0]         x_cnt_d;
    logic [11:0]         y_cnt_q;
    logic [11:0]         y_cnt_d;
    logic [11:0]         y_cnt_inc;

    logic                pix_vld_q;
    logic                pix_first_q;
    logic [15:0]         pix_q;

    logic                wr_en_q;
    logic [23:0]         rgb_q;
    logic                frame_start_q;
    logic                line_err_q;
    logic                frame_err_q;

    logic                vs_rise;
    logic                h_fall;
    logic                in_capture;
    logic                pix_done;
    logic                pix_wr;
    logic                pix_first;
    logic                line_seen;
    logic                line_err_set;
    logic                frame_err_set;

    function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    assign vs_rise    = v_r_q & ~v_rd_q;
    assign h_fall     = h_rd_q & ~h_r_q;
    assign in_capture = (state_q == ST_CAPTURE);
    assign pix_done   = h_r_q & toggle_q;
    assign pix_wr     = pix_done & in_capture & sys_init_done &
                        (x_cnt_q < H_LIM) & (y_cnt_q < V_LIM);
    assign pix_first  = pix_wr & (x_cnt_q == 12'd0) & (y_cnt_q == 12'd0);
    assign line_seen  = h_fall & (x_cnt_q != 12'd0);
    assign y_cnt_inc  = (line_seen && (y_cnt_q != CNT_MAX)) ? y_cnt_q + 12'd1 : y_cnt_q;

    // A line ending on the same cycle as vsync still counts toward the frame check
    assign line_err_set  = h_fall & in_capture & ((x_cnt_q != H_LIM) | toggle_q);
    assign frame_err_set = vs_rise & in_capture & (y_cnt_inc != V_LIM);

    always_comb begin
        toggle_d = toggle_q;
        hi_d     = hi_q;
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_inc;

        if (h_r_q) begin
            if (!toggle_q) begin
                hi_d = d_r_q;
            end
            toggle_d = ~toggle_q;
        end else begin
            toggle_d = 1'b0;
        end

        if (pix_done && (x_cnt_q != CNT_MAX)) begin
            x_cnt_d = x_cnt_q + 12'd1;
        end
        if (h_fall) begin
            x_cnt_d = 12'd0;
        end

        // The completing pixel above was already judged against the old frame
        if (vs_rise) begin
            toggle_d = 1'b0;
            y_cnt_d  = 12'd0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            skip_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    skip_cnt_q <= SKIP_LOAD;
                    if (sys_init_done) begin
                        state_q <= ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (!sys_init_done) begin
                        state_q <= ST_IDLE;
                    end else if (vs_rise) begin
                        if (skip_cnt_q == SKIP_LAST) begin
                            state_q <= ST_CAPTURE;
                        end
                        skip_cnt_q <= skip_cnt_q - SKIP_LAST;
                    end
                end
                ST_CAPTURE: begin
                    if (!sys_init_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            v_r_q         <= 1'b0;
            v_rd_q        <= 1'b0;
            h_r_q         <= 1'b0;
            h_rd_q        <= 1'b0;
            d_r_q         <= 8'd0;
            toggle_q      <= 1'b0;
            hi_q          <= 8'd0;
            x_cnt_q       <= 12'd0;
            y_cnt_q       <= 12'd0;
            pix_vld_q     <= 1'b0;
            pix_first_q   <= 1'b0;
            pix_q         <= 16'd0;
            wr_en_q       <= 1'b0;
            rgb_q         <= 24'd0;
            frame_start_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            v_r_q    <= ov5640_vsync;
            v_rd_q   <= v_r_q;
            h_r_q    <= ov5640_href;
            h_rd_q   <= h_r_q;
            d_r_q    <= ov5640_data;

            toggle_q <= toggle_d;
            hi_q     <= hi_d;
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;

            pix_vld_q   <= pix_wr;
            pix_first_q <= pix_first;
            if (pix_wr) begin
                pix_q <= {hi_q, d_r_q};
            end

            // Losing init cancels a pixel already in flight
            wr_en_q       <= pix_vld_q & sys_init_done;
            frame_start_q <= pix_first_q & sys_init_done;
            if (pix_vld_q && sys_init_done) begin
                rgb_q <= rgb565_to_888(pix_q);
            end

            if (line_err_set) begin
                line_err_q <= 1'b1;
            end
            if (frame_err_set) begin
                frame_err_q <= 1'b1;
            end
        end
    end

    assign ov5640_wr_en    = wr_en_q;
    assign ov5640_data_out = rgb_q;
    assign frame_start     = frame_start_q;
    assign line_err        = line_err_q;
    assign frame_err       = frame_err_q;

endmodule

// File: tb/tb_ov5640_pix_capture.sv
`timescale 1ns/1ps
// Bench for ov5640_pix_capture: drives DVP frames with small geometry and checks
// every write against a frame/line/pixel-level reference model.
module tb_ov5640_pix_capture;

    localparam int PIC_WAIT = 2;
    localparam int H        = 8;
    localparam int V        = 4;

    logic        clk = 1'b0;
    logic        sys_rst;
    logic        sys_init_done;
    logic        vsync;
    logic        href;
    logic [7:0]  data;
    logic        wr_en;
    logic [23:0] data_out;
    logic        fs;
    logic        line_err;
    logic        frame_err;

    always #5 clk = ~clk;

    ov5640_pix_capture #(
        .PIC_WAIT (PIC_WAIT),
        .H_PIXEL  (H),
        .V_PIXEL  (V)
    ) dut (
        .sys_clk         (clk),
        .sys_rst         (sys_rst),
        .sys_init_done   (sys_init_done),
        .ov5640_vsync    (vsync),
        .ov5640_href     (href),
        .ov5640_data     (data),
        .ov5640_wr_en    (wr_en),
        .ov5640_data_out (data_out),
        .frame_start     (fs),
        .line_err        (line_err),
        .frame_err       (frame_err)
    );

    typedef struct {
        logic [23:0] rgb;
        logic        fs;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [23:0] rgb;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          got_n = 0;
    int          fs_n = 0;
    wr_t         exp_q[$];
    wr_t         got_log[$];
    int          lo_log[$];
    logic [7:0]  src_q[$];
    vec_t        tbl[8];

    bit          init_m;
    bit          capturing_m;
    int          vs_count;
    int          line_y;
    bit          line_err_m;
    bit          frame_err_m;
    logic [23:0] last_rgb_m = 24'd0;
    int          rst_pending = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    endtask

    function automatic logic [23:0] rgb_model(input int hi, input int lo);
        int r5, g6, b5;
        r5 = hi / 8;
        g6 = (hi % 8) * 8 + lo / 32;
        b5 = lo % 32;
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        wr_t g;
        wr_t e;
        chk("fs_only_with_wr", 32'(fs & ~wr_en), 32'd0);
        if (sys_rst) last_rgb_m = 24'd0;
        if (wr_en) begin
            g.rgb = data_out;
            g.fs  = fs;
            g.cyc = cyc;
            got_log.push_back(g);
            got_n++;
            if (g.fs) fs_n++;
            chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_cycle", g.cyc, e.cyc);
                chk("wr_rgb", 32'(g.rgb), 32'(e.rgb));
                chk("wr_fs", 32'(g.fs), 32'(e.fs));
                last_rgb_m = e.rgb;
            end
        end else if (!sys_rst) begin
            chk("data_hold", 32'(data_out), 32'(last_rgb_m));
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk("wr_missing", cyc, e.cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        if (rst_pending == 2) begin
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_data_out", 32'(data_out), 32'd0);
            chk("rst_frame_start", 32'(fs), 32'd0);
            chk("rst_line_err", 32'(line_err), 32'd0);
            chk("rst_frame_err", 32'(frame_err), 32'd0);
            rst_pending = 1;
        end else if (rst_pending == 1) begin
            sys_rst = 1'b0;
            rst_pending = 0;
        end
    endtask

    task automatic flush_from(input int lim);
        while (exp_q.size() > 0 && exp_q[$].cyc >= lim) void'(exp_q.pop_back());
    endtask

    // cut_kind: 0 none, 1 drop sys_init_done, 2 assert sys_rst, at byte cut_at
    task automatic drive_line(input int nbytes, input int cut_at, input int cut_kind);
        logic [7:0] b;
        logic [7:0] hi_b;
        int px;
        hi_b = 8'd0;
        for (int i = 0; i < nbytes; i++) begin
            step();
            b = (src_q.size() > 0) ? src_q.pop_front() : 8'($urandom_range(0, 255));
            href = 1'b1;
            data = b;
            if (i == cut_at && cut_kind != 0) begin
                if (cut_kind == 1) begin
                    sys_init_done = 1'b0;
                    init_m = 1'b0;
                end else begin
                    sys_rst = 1'b1;
                    rst_pending = 2;
                    line_err_m = 1'b0;
                    frame_err_m = 1'b0;
                end
                capturing_m = 1'b0;
                vs_count = 0;
                flush_from(cyc + 1);
            end
            if (i % 2 == 0) begin
                hi_b = b;
            end else begin
                px = i / 2;
                lo_log.push_back(cyc + 1);
                if (capturing_m && init_m && px < H && line_y < V)
                    exp_q.push_back('{rgb_model(int'(hi_b), int'(b)), (px == 0 && line_y == 0), cyc + 3});
            end
        end
        step();
        href = 1'b0;
        data = 8'($urandom_range(0, 255));
        if (nbytes >= 2) line_y++;
        if (capturing_m && ((nbytes / 2 != H) || (nbytes % 2 != 0))) line_err_m = 1'b1;
        repeat (3) step();
    endtask

    task automatic drive_vsync();
        step();
        vsync = 1'b1;
        if (capturing_m && line_y != V) frame_err_m = 1'b1;
        if (init_m) begin
            vs_count++;
            if (vs_count >= PIC_WAIT) capturing_m = 1'b1;
        end
        line_y = 0;
        repeat (2) step();
        vsync = 1'b0;
        repeat (3) step();
    endtask

    task automatic drive_frame(input int nlines, input int nbytes);
        for (int l = 0; l < nlines; l++) drive_line(nbytes, -1, 0);
        drive_vsync();
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_line_err"}, 32'(line_err), 32'(line_err_m));
        chk({tag, "_frame_err"}, 32'(frame_err), 32'(frame_err_m));
    endtask

    initial begin
        int n0;
        int f0;
        tbl[0] = '{8'hF8, 8'h00, 24'hFF0000};
        tbl[1] = '{8'h07, 8'hE0, 24'h00FF00};
        tbl[2] = '{8'h00, 8'h1F, 24'h0000FF};
        tbl[3] = '{8'h84, 8'h10, 24'h848284};
        tbl[4] = '{8'h00, 8'h00, 24'h000000};
        tbl[5] = '{8'hFF, 8'hFF, 24'hFFFFFF};
        tbl[6] = '{8'hA5, 8'h5A, 24'hA5AAD6};
        tbl[7] = '{8'h12, 8'h34, 24'h1045A5};

        sys_rst = 1'b1; sys_init_done = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'd0;
        init_m = 1'b0; capturing_m = 1'b0; vs_count = 0; line_y = 0;
        line_err_m = 1'b0; frame_err_m = 1'b0;
        repeat (3) step();
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_frame_start", 32'(fs), 32'd0);
        check_flags("reset");
        sys_rst = 1'b0;
        step();
        sys_init_done = 1'b1; init_m = 1'b1;
        repeat (4) step();

        // start-up frames are discarded, then one full frame is written
        n0 = got_n;
        repeat (PIC_WAIT) drive_frame(V, 2 * H);
        chk("skip_writes", got_n - n0, 0);
        n0 = got_n; f0 = fs_n;
        drive_frame(V, 2 * H);
        chk("frame_writes", got_n - n0, H * V);
        chk("frame_start_count", fs_n - f0, 1);
        check_flags("first_frame");

        // colour table with latency check
        foreach (tbl[i]) begin
            src_q.push_back(tbl[i].hi);
            src_q.push_back(tbl[i].lo);
        end
        lo_log.delete();
        n0 = got_log.size();
        drive_line(2 * H, -1, 0);
        chk("tbl_count", got_log.size() - n0, H);
        for (int i = 0; i < H; i++) begin
            if (n0 + i < got_log.size()) begin
                chk($sformatf("tbl_rgb_%0d", i), 32'(got_log[n0 + i].rgb), 32'(tbl[i].rgb));
                chk($sformatf("tbl_latency_%0d", i), got_log[n0 + i].cyc, lo_log[i] + 2);
            end
        end
        for (int l = 1; l < V; l++) drive_line(2 * H, -1, 0);
        drive_vsync();
        check_flags("table_frame");

        // long line then short line
        n0 = got_n;
        drive_line(2 * (H + 2), -1, 0);
        drive_line(2 * (H - 2), -1, 0);
        chk("long_short_writes", got_n - n0, H + (H - 2));
        chk("line_err_after_short", 32'(line_err), 32'd1);
        for (int l = 2; l < V; l++) drive_line(2 * H, -1, 0);
        drive_vsync();
        chk("line_err_sticky", 32'(line_err), 32'd1);
        check_flags("long_short_frame");

        // reset in the middle of a captured frame
        drive_line(2 * H, -1, 0);
        chk("line_err_before_rst", 32'(line_err), 32'd1);
        drive_line(2 * H, 5, 2);
        n0 = got_n;
        for (int l = 2; l < V; l++) drive_line(2 * H, -1, 0);
        drive_vsync();
        repeat (PIC_WAIT - 1) drive_frame(V, 2 * H);
        chk("post_rst_skip_writes", got_n - n0, 0);
        check_flags("post_rst");

        // odd byte count line followed by a normal line
        n0 = got_n;
        drive_line(2 * H + 1, -1, 0);
        chk("odd_line_writes", got_n - n0, H);
        chk("odd_line_err", 32'(line_err), 32'd1);
        for (int l = 1; l < V; l++) drive_line(2 * H, -1, 0);
        drive_vsync();
        chk("odd_frame_writes", got_n - n0, H * V);
        check_flags("odd_frame");

        // too many lines: clipped writes, frame_err at the next vsync
        n0 = got_n;
        for (int l = 0; l < V + 2; l++) drive_line(2 * H, -1, 0);
        check_flags("tall_before_vs");
        chk("frame_err_before_vs", 32'(frame_err), 32'd0);
        drive_vsync();
        chk("tall_writes", got_n - n0, H * V);
        chk("frame_err_after_vs", 32'(frame_err), 32'd1);

        // init dropped mid-line, then re-armed
        drive_line(2 * H, -1, 0);
        drive_line(2 * H, 7, 1);
        repeat (5) step();
        sys_init_done = 1'b1; init_m = 1'b1;
        repeat (4) step();
        n0 = got_n;
        drive_line(2 * H, -1, 0);
        drive_vsync();
        repeat (PIC_WAIT - 1) drive_frame(V, 2 * H);
        chk("rearm_skip_writes", got_n - n0, 0);
        n0 = got_n; f0 = fs_n;
        drive_frame(V, 2 * H);
        chk("rearm_frame_writes", got_n - n0, H * V);
        chk("rearm_frame_start", fs_n - f0, 1);
        check_flags("final");

        repeat (5) step();
        chk("expected_left", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
